// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
// Shared definitions for the serial frame transmitter: FSM state encoding,
// line levels for idle/start/stop, and the frame length helper.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Cycles per frame: start bit + data bits + stop bit.
    function automatic int frame_len(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/serial_frame_tx_piso_shift.sv
// piso_shift
// WIDTH-bit parallel-load shift register with zero fill.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, clears the register
//   load   - capture d (has priority over shift)
//   shift  - move one bit toward the outgoing end
//   d      - parallel word
//   q_bit  - bit currently at the outgoing end (MSB or LSB per MSB_FIRST)
module piso_shift #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_bit
);

    logic [WIDTH-1:0] sr;

    generate
        if (MSB_FIRST) begin : g_msb
            always_ff @(posedge clk) begin
                if (reset)      sr <= '0;
                else if (load)  sr <= d;
                else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
            end
            assign q_bit = sr[WIDTH-1];
        end else begin : g_lsb
            always_ff @(posedge clk) begin
                if (reset)      sr <= '0;
                else if (load)  sr <= d;
                else if (shift) sr <= {1'b0, sr[WIDTH-1:1]};
            end
            assign q_bit = sr[0];
        end
    endgenerate

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Parallel-to-serial framing transmitter. Accepts a word over valid/ready
// and sends start bit, WIDTH data bits, stop bit on a line that idles high.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset (drops any frame in flight)
//   in_data  - parallel word, captured only on accept
//   in_valid - in_data is valid
//   in_ready - word can be accepted this cycle (IDLE or STOP)
//   out      - registered serial line
//   busy     - frame in progress
//
// state | meaning
// IDLE  | line high, waiting for a word
// START | start bit (low) on the line
// DATA  | data bits on the line, bit_cnt = index of bit shown
// STOP  | stop bit (high); may accept the next word for a gapless frame
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             shift;
    logic             q_bit;

    assign in_ready = (state == IDLE) || (state == STOP);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // out is registered, so the register is advanced on the same edge that
    // puts its current head bit on the line: once leaving START, and on every
    // DATA edge except the one that moves to STOP.
    assign shift = (state == START) || ((state == DATA) && (bit_cnt != LAST_BIT));

    piso_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift),
        .d     (in_data),
        .q_bit (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            out     <= IDLE_LEVEL;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= START;
                        out     <= START_LEVEL;
                        bit_cnt <= '0;
                    end else begin
                        out <= IDLE_LEVEL;
                    end
                end
                START: begin
                    state <= DATA;
                    out   <= q_bit;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        state <= STOP;
                        out   <= STOP_LEVEL;
                    end else begin
                        out     <= q_bit;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (accept) begin
                        state   <= START;
                        out     <= START_LEVEL;
                        bit_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        out   <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
// Self-checking bench: an MSB-first and an LSB-first transmitter (WIDTH=8)
// share clock, reset and producer inputs; outputs are compared against
// hand-written vectors and a small frame model.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       rdy_m, out_m, busy_m;
    logic       rdy_l, out_l, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .out(out_m), .busy(busy_m)
    );

    serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .out(out_l), .busy(busy_l)
    );

    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         exp_m;
        bit         exp_l;
        bit         exp_rdy;
        bit         exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input bit v, input logic [7:0] d, input bit em,
                                input bit el, input bit er, input bit eb);
        vec_t t;
        t.valid = v; t.data = d; t.exp_m = em; t.exp_l = el; t.exp_rdy = er; t.exp_busy = eb;
        vecs.push_back(t);
    endfunction

    function automatic bit data_bit(input logic [7:0] w, input bit msb, input int i);
        return msb ? w[7-i] : w[i];
    endfunction

    // Line level n cycles after accepting w0 at edge 0, with w1 accepted
    // during the first stop bit (two frames back to back).
    function automatic bit exp_two(input int n, input logic [7:0] w0,
                                   input logic [7:0] w1, input bit msb);
        if (n == 1 || n == 11)      return 1'b0;
        if (n >= 2 && n <= 9)       return data_bit(w0, msb, n - 2);
        if (n >= 12 && n <= 19)     return data_bit(w1, msb, n - 12);
        return 1'b1;
    endfunction

    function automatic bit exp_one(input int n, input logic [7:0] w, input bit msb);
        if (n == 1)            return 1'b0;
        if (n >= 2 && n <= 9)  return data_bit(w, msb, n - 2);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two words with in_valid held: w1 is offered from cycle 1 (or after a
    // toggling burst of junk if toggle=1) and must only be taken in STOP.
    task automatic two_frames(input string name, input logic [7:0] w0,
                              input logic [7:0] w1, input bit toggle);
        int  accepts = 0;
        bit  acc;
        in_valid = 1'b1;
        in_data  = w0;
        for (int c = 0; c <= 20; c++) begin
            acc = in_valid && rdy_m;
            tick();
            if (acc) accepts++;
            chk({name, "_out_m"}, out_m, exp_two(c + 1, w0, w1, 1'b1));
            chk({name, "_out_l"}, out_l, exp_two(c + 1, w0, w1, 1'b0));
            if (accepts >= 2)               in_valid = 1'b0;
            else if (toggle && (c + 1) < 10) in_data = ((c + 1) % 2 == 1) ? 8'hFF : 8'h00;
            else                             in_data = w1;
        end
        chk({name, "_accepts"}, accepts, 2);
        chk({name, "_busy_end"}, busy_m, 1'b0);
    endtask

    initial begin
        // Reset held with a word offered: nothing may be accepted.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_m", out_m, 1'b1);
            chk("rst_out_l", out_l, 1'b1);
            chk("rst_busy", busy_m, 1'b0);
            chk("rst_ready", rdy_m, 1'b1);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_rst_busy", busy_m, 1'b0);
        chk("post_rst_out", out_m, 1'b1);

        // 0xA5: bits identical in both orders. 0x01: distinguishes orders.
        // Data is scrambled while in_valid is low to show it is ignored.
        add(1, 8'hA5, 0, 0, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1);
        add(0, 8'hFF, 1, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1);
        add(0, 8'hFF, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 1, 1);
        add(0, 8'h00, 1, 1, 1, 0);
        add(1, 8'h01, 0, 0, 0, 1);
        add(0, 8'hFF, 0, 1, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'hFF, 0, 0, 0, 1);
        add(0, 8'hFF, 1, 0, 0, 1);
        add(0, 8'hFF, 1, 1, 1, 1);
        add(0, 8'hFF, 1, 1, 1, 0);
        add(0, 8'hFF, 1, 1, 1, 0);

        foreach (vecs[i]) begin
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_out_m", i), out_m, vecs[i].exp_m);
            chk($sformatf("vec%0d_out_l", i), out_l, vecs[i].exp_l);
            chk($sformatf("vec%0d_ready", i), rdy_m, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_busy", i), busy_m, vecs[i].exp_busy);
            chk($sformatf("vec%0d_busy_l", i), busy_l, vecs[i].exp_busy);
        end
        in_valid = 1'b0;

        two_frames("b2b", 8'h00, 8'hFF, 1'b0);
        tick();
        two_frames("bp", 8'h96, 8'h5A, 1'b1);
        tick();

        // Reset right after data bit 3 of 0x3C.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        for (int n = 1; n <= 5; n++) begin
            tick();
            in_valid = 1'b0;
            in_data  = 8'hC3;
            chk("mid_out_m", out_m, exp_one(n, 8'h3C, 1'b1));
            chk("mid_out_l", out_l, exp_one(n, 8'h3C, 1'b0));
        end
        reset = 1'b1;
        tick();
        chk("mid_rst_out", out_m, 1'b1);
        chk("mid_rst_busy", busy_m, 1'b0);
        chk("mid_rst_ready", rdy_m, 1'b1);
        reset = 1'b0;
        tick();
        chk("mid_idle_busy", busy_m, 1'b0);

        in_valid = 1'b1;
        in_data  = 8'h81;
        for (int n = 1; n <= 11; n++) begin
            tick();
            in_valid = 1'b0;
            in_data  = 8'h00;
            chk("after_out_m", out_m, exp_one(n, 8'h81, 1'b1));
            chk("after_out_l", out_l, exp_one(n, 8'h81, 1'b0));
        end
        chk("after_busy", busy_m, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
